// File: rtl/prog_loader_if.sv
// prog_loader_if: bundles the loader's byte-stream handshake, program memory
// write port and CPU control/status lines.
//   rx_data/rx_valid/rx_ready  byte stream in (valid/ready handshake)
//   prog_addr/prog_data/prog_we  program memory write port
//   cpu_reset/busy/done/error  CPU reset and loader status
// Modports: slave = loader side, master = byte source / memory / observer side.
interface prog_loader_if #(
    parameter int unsigned PC_N = 8
);
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            rx_ready;
    logic [PC_N-1:0] prog_addr;
    logic [15:0]     prog_data;
    logic            prog_we;
    logic            cpu_reset;
    logic            busy;
    logic            done;
    logic            error;

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, prog_addr, prog_data, prog_we, cpu_reset, busy, done, error
    );

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, prog_addr, prog_data, prog_we, cpu_reset, busy, done, error
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: boot loader in front of the CPU instruction ROM port.
// Accepts frames HDR, CNT, (CNT+1) x {hi, lo}, CSUM; writes the words to
// program memory from address 0 and releases cpu_reset only when the 8-bit
// sum of CNT, payload and CSUM is zero.
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  prog_loader_if.slave: rx handshake, program write port, status
module prog_loader #(
    parameter int unsigned PC_N    = 8,
    parameter int unsigned TIMEOUT = 65535,
    parameter logic [7:0]  HDR     = 8'hA5
) (
    input logic         clk,
    input logic         rst,
    prog_loader_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StHi,
        StLo,
        StCsum,
        StDone,
        StErr
    } state_t;

    // Largest CNT that still fits the address space (9 bits so PC_N = 8 works).
    localparam logic [8:0]  MAX_CNT  = 9'((1 << PC_N) - 1);
    // Going to ERR on the edge where the counter would reach TIMEOUT.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      hi_q, hi_d;
    logic [7:0]      idx_q, idx_d;
    logic [7:0]      acc_q, acc_d;
    logic [15:0]     tmo_q, tmo_d;
    logic [PC_N-1:0] addr_q, addr_d;
    logic [15:0]     data_q, data_d;
    logic            we_q, we_d;
    logic            cpu_reset_q, cpu_reset_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    logic       accept;
    logic       active;
    logic       timed_out;
    logic [7:0] acc_sum;

    // No byte is taken while the write strobe is out.
    assign accept    = bus.rx_valid & ~we_q;
    assign active    = state_q inside {StCount, StHi, StLo, StCsum};
    assign timed_out = active && (tmo_q == TMO_LAST);
    assign acc_sum   = acc_q + bus.rx_data;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        addr_d      = addr_q;
        data_d      = data_q;
        we_d        = 1'b0;
        cpu_reset_d = cpu_reset_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        tmo_d       = active ? 16'(tmo_q + 16'd1) : 16'd0;
        if (accept) begin
            tmo_d = 16'd0;
        end

        if (timed_out) begin
            // Timeout wins over a byte arriving this cycle; that byte is dropped.
            state_d = StErr;
            error_d = 1'b1;
            busy_d  = 1'b0;
        end else if (accept) begin
            unique case (state_q)
                StIdle, StDone, StErr: begin
                    if (bus.rx_data == HDR) begin
                        state_d     = StCount;
                        acc_d       = 8'd0;
                        idx_d       = 8'd0;
                        tmo_d       = 16'd0;
                        busy_d      = 1'b1;
                        cpu_reset_d = 1'b1;
                        done_d      = 1'b0;
                        error_d     = 1'b0;
                    end
                end
                StCount: begin
                    cnt_d = bus.rx_data;
                    acc_d = acc_sum;
                    if ({1'b0, bus.rx_data} > MAX_CNT) begin
                        state_d = StErr;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = StHi;
                    end
                end
                StHi: begin
                    hi_d    = bus.rx_data;
                    acc_d   = acc_sum;
                    state_d = StLo;
                end
                StLo: begin
                    acc_d   = acc_sum;
                    we_d    = 1'b1;
                    data_d  = {hi_q, bus.rx_data};
                    addr_d  = idx_q[PC_N-1:0];
                    idx_d   = idx_q + 8'd1;
                    state_d = (idx_q == cnt_q) ? StCsum : StHi;
                end
                StCsum: begin
                    busy_d = 1'b0;
                    if (acc_sum == 8'd0) begin
                        state_d     = StDone;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            hi_q        <= 8'd0;
            idx_q       <= 8'd0;
            acc_q       <= 8'd0;
            tmo_q       <= 16'd0;
            addr_q      <= '0;
            data_q      <= 16'd0;
            we_q        <= 1'b0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            tmo_q       <= tmo_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            we_q        <= we_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign bus.rx_ready  = ~we_q;
    assign bus.prog_addr = addr_q;
    assign bus.prog_data = data_q;
    assign bus.prog_we   = we_q;
    assign bus.cpu_reset = cpu_reset_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader.
// Uses PC_N = 4 (so CNT overflow is reachable) and TIMEOUT = 16.
module tb_prog_loader;

    localparam int unsigned PC_N    = 4;
    localparam int unsigned TIMEOUT = 16;

    typedef logic [7:0] bytes_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    prog_loader_if #(.PC_N(PC_N)) bus ();

    prog_loader #(
        .PC_N   (PC_N),
        .TIMEOUT(TIMEOUT),
        .HDR    (8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Write capture and rx_ready/prog_we relationship, sampled mid-cycle.
    logic [PC_N-1:0] wr_addr[$];
    logic [15:0]     wr_data[$];
    int              ready_viol = 0;

    always @(negedge clk) begin
        if (bus.prog_we === 1'b1) begin
            wr_addr.push_back(bus.prog_addr);
            wr_data.push_back(bus.prog_data);
        end
        if (!rst && (bus.rx_ready !== ~bus.prog_we)) ready_viol++;
    end

    logic    pre_cpu_reset;
    time     last_accept;
    time     first_accept;
    bytes_t  frame;
    int      first_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a byte and return 1 time unit after the edge that accepts it;
    // rx_valid is left high so consecutive calls stream back-to-back.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n >= 8) check("rx_ready_wait", 32'(n), 32'd0);
        pre_cpu_reset = bus.cpu_reset;
        @(posedge clk);
        last_accept = $time;
        #1;
    endtask

    task automatic send_list(input bytes_t bs);
        foreach (bs[i]) begin
            send_byte(bs[i]);
            if (i == 0) first_accept = last_accept;
        end
    endtask

    task automatic rx_stop();
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'd1);
        check({tag, "_rx_ready"},  32'(bus.rx_ready),  32'd1);
        check({tag, "_prog_we"},   32'(bus.prog_we),   32'd0);
        check({tag, "_prog_addr"}, 32'(bus.prog_addr), 32'd0);
        check({tag, "_prog_data"}, 32'(bus.prog_data), 32'd0);
        check({tag, "_busy"},      32'(bus.busy),      32'd0);
        check({tag, "_done"},      32'(bus.done),      32'd0);
        check({tag, "_error"},     32'(bus.error),     32'd0);
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        #12;
        check_reset_values("rst");
        @(negedge clk);
        rst = 1'b0;

        // Good frame, streamed back-to-back. Sum 01+12+34+56+78 = 0x15 -> CSUM 0xEB.
        wr_addr.delete(); wr_data.delete();
        frame = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'hEB};
        send_list(frame);
        // 7 bytes plus one stall cycle per write strobe.
        check("good_latency", 32'((last_accept - first_accept) / 10), 32'd8);
        check("good_cpu_reset_pre", 32'(pre_cpu_reset), 32'd1);
        check("good_cpu_reset", 32'(bus.cpu_reset), 32'd0);
        check("good_done", 32'(bus.done), 32'd1);
        check("good_error", 32'(bus.error), 32'd0);
        check("good_busy", 32'(bus.busy), 32'd0);
        rx_stop();
        check("good_nwr", 32'(wr_addr.size()), 32'd2);
        check("good_addr0", 32'(wr_addr[0]), 32'd0);
        check("good_data0", 32'(wr_data[0]), 32'h1234);
        check("good_addr1", 32'(wr_addr[1]), 32'd1);
        check("good_data1", 32'(wr_data[1]), 32'h5678);

        // Same frame with a wrong checksum.
        wr_addr.delete(); wr_data.delete();
        frame = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h95};
        send_list(frame);
        check("bad_error", 32'(bus.error), 32'd1);
        check("bad_done", 32'(bus.done), 32'd0);
        check("bad_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        rx_stop();
        check("bad_nwr", 32'(wr_addr.size()), 32'd2);
        check("bad_data1", 32'(wr_data[1]), 32'h5678);

        // Leading junk is ignored while in ERR.
        wr_addr.delete(); wr_data.delete();
        send_byte(8'h00);
        send_byte(8'hFF);
        check("junk_error_held", 32'(bus.error), 32'd1);
        check("junk_busy", 32'(bus.busy), 32'd0);
        frame = '{8'hA5, 8'h00, 8'hAB, 8'hCD, 8'h88};
        send_list(frame);
        check("junk_done", 32'(bus.done), 32'd1);
        check("junk_error", 32'(bus.error), 32'd0);
        rx_stop();
        check("junk_nwr", 32'(wr_addr.size()), 32'd1);
        check("junk_addr0", 32'(wr_addr[0]), 32'd0);
        check("junk_data0", 32'(wr_data[0]), 32'hABCD);

        // Reload after DONE. Sum 01+11+11+22+22 = 0x67 -> CSUM 0x99.
        wr_addr.delete(); wr_data.delete();
        send_byte(8'hA5);
        check("reload_cpu_reset_pre", 32'(pre_cpu_reset), 32'd0);
        check("reload_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        check("reload_done_clr", 32'(bus.done), 32'd0);
        check("reload_busy", 32'(bus.busy), 32'd1);
        frame = '{8'h01, 8'h11, 8'h11, 8'h22, 8'h22, 8'h99};
        send_list(frame);
        check("reload_done", 32'(bus.done), 32'd1);
        rx_stop();
        check("reload_nwr", 32'(wr_addr.size()), 32'd2);
        check("reload_addr0", 32'(wr_addr[0]), 32'd0);
        check("reload_data0", 32'(wr_data[0]), 32'h1111);
        check("reload_data1", 32'(wr_data[1]), 32'h2222);

        // CNT = 16 does not fit 4 address bits.
        frame = '{8'hA5, 8'h10};
        send_list(frame);
        check("ovf_error", 32'(bus.error), 32'd1);
        check("ovf_busy", 32'(bus.busy), 32'd0);
        check("ovf_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        rx_stop();

        // Timeout: stall after the first high byte.
        wr_addr.delete(); wr_data.delete();
        frame = '{8'hA5, 8'h00, 8'hAB};
        send_list(frame);
        check("tmo_error_clr", 32'(bus.error), 32'd0);
        rx_stop();
        first_err = 0;
        for (int k = 1; k <= 40 && first_err == 0; k++) begin
            @(posedge clk);
            #1;
            if (bus.error === 1'b1) first_err = k;
        end
        check("tmo_cycle", 32'(first_err), 32'd16);
        check("tmo_busy", 32'(bus.busy), 32'd0);
        check("tmo_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        check("tmo_nwr", 32'(wr_addr.size()), 32'd0);

        // Reset mid-frame after the high byte, away from a clock edge.
        wr_addr.delete(); wr_data.delete();
        frame = '{8'hA5, 8'h01, 8'h12};
        send_list(frame);
        rx_stop();
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst = 1'b0;
        check("midrst_nwr", 32'(wr_addr.size()), 32'd0);
        frame = '{8'hA5, 8'h00, 8'hAB, 8'hCD, 8'h88};
        send_list(frame);
        check("after_rst_done", 32'(bus.done), 32'd1);
        check("after_rst_cpu_reset", 32'(bus.cpu_reset), 32'd0);
        rx_stop();
        check("after_rst_nwr", 32'(wr_addr.size()), 32'd1);
        check("after_rst_data0", 32'(wr_data[0]), 32'hABCD);

        // Write port holds its last values after DONE.
        repeat (3) @(posedge clk);
        #1;
        check("hold_addr", 32'(bus.prog_addr), 32'd0);
        check("hold_data", 32'(bus.prog_data), 32'hABCD);
        check("hold_we", 32'(bus.prog_we), 32'd0);
        check("hold_done", 32'(bus.done), 32'd1);

        check("rx_ready_vs_we", 32'(ready_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
